// File: rtl/cam_link_pkg.sv
// Shared constants and receiver state encoding for the 1-bit thresholded camera link.
// The capture side uses the same frame geometry.
package cam_link_pkg;

    localparam int FRAME_W      = 320;
    localparam int FRAME_H      = 240;
    localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
    localparam int ADDR_W       = 14;

    typedef enum logic [2:0] {
        RESYNC,
        IDLE,
        RECEIVE,
        FLUSH,
        DONE
    } rx_state_t;

endpackage

// File: rtl/link_sync.sv
// Multi-flop synchroniser for the link inputs, with one extra history stage for edge detection.
// `primed` rises once every stage holds a real sample taken after reset.
module link_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 4
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_cur,
    output logic [WIDTH-1:0] sync_prev,
    output logic             primed
);

    logic [STAGES-1:0][WIDTH-1:0] chain_q;
    logic [STAGES:0]              fill_q;

    // NOTE: synchroniser flops are reset so that edge history never starts from X.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            chain_q   <= '0;
            sync_prev <= '0;
            fill_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the old value of its neighbour.
            chain_q[0] <= async_in;
            for (int i = 1; i < STAGES; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
            sync_prev <= chain_q[STAGES-1];
            fill_q    <= {fill_q[STAGES-1:0], 1'b1};
        end
    end

    assign sync_cur = chain_q[STAGES-1];
    assign primed   = fill_q[STAGES];

endmodule

// File: rtl/bitmask_stream_receiver.sv
// Receiver for the 1-bit camera link: samples on synced pclk falling edges, packs bits
// MSB-first into addressed bytes and reports frame start, completion and integrity.
module bitmask_stream_receiver #(
    parameter int FRAME_PIXELS = cam_link_pkg::FRAME_PIXELS,
    parameter int ADDR_W       = cam_link_pkg::ADDR_W,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              link_pclk,
    input  logic              link_in_frame,
    input  logic              link_wr_en,
    input  logic              link_data,
    output logic              byte_valid,
    output logic [7:0]        byte_data,
    output logic [ADDR_W-1:0] byte_addr,
    output logic              frame_start,
    output logic              frame_done,
    output logic              frame_ok,
    output logic [16:0]       pixel_count
);
    import cam_link_pkg::*;

    localparam logic [16:0] PIX_MAX = 17'(FRAME_PIXELS);

    logic [3:0] link_cur;
    logic [3:0] link_prev;
    logic       link_primed;

    link_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (4)
    ) u_link_sync (
        .clk       (clk),
        .nreset    (nreset),
        .async_in  ({link_data, link_wr_en, link_in_frame, link_pclk}),
        .sync_cur  (link_cur),
        .sync_prev (link_prev),
        .primed    (link_primed)
    );

    logic pclk_fall;
    logic in_frame_s;
    logic wr_en_s;
    logic data_s;

    assign pclk_fall  = link_prev[0] & ~link_cur[0];
    assign in_frame_s = link_cur[1];
    assign wr_en_s    = link_cur[2];
    assign data_s     = link_cur[3];

    rx_state_t         state_q, state_d;
    logic [7:0]        shift_q;
    logic [2:0]        bit_idx_q;
    logic [ADDR_W-1:0] addr_cnt_q;
    logic              byte_full_q;
    logic              overflow_q;

    logic       bit_valid;
    logic       take_bit;
    logic       drop_bit;
    logic [2:0] bit_idx_d;
    logic       frame_begin;
    logic       frame_end;
    logic [7:0] flush_byte;

    // NOTE: every signal written here gets a default first, so no path infers a latch.
    always_comb begin
        bit_valid   = (state_q == RECEIVE) && pclk_fall && wr_en_s;
        take_bit    = bit_valid && (pixel_count < PIX_MAX);
        drop_bit    = bit_valid && (pixel_count >= PIX_MAX);
        bit_idx_d   = take_bit ? bit_idx_q + 3'd1 : bit_idx_q;
        frame_begin = 1'b0;
        frame_end   = 1'b0;
        state_d     = state_q;

        unique case (state_q)
            RESYNC:  if (link_primed && !in_frame_s) state_d = IDLE;
            IDLE: begin
                // Level test, so a frame that rose during FLUSH/DONE is still picked up.
                if (in_frame_s) begin
                    state_d     = RECEIVE;
                    frame_begin = 1'b1;
                end
            end
            // A sample event in the same cycle is already folded into bit_idx_d.
            RECEIVE: if (!in_frame_s) state_d = (bit_idx_d != 3'd0) ? FLUSH : DONE;
            FLUSH:   state_d = DONE;
            DONE: begin
                if (!byte_full_q) begin
                    state_d   = IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_d = RESYNC;
        endcase
    end

    assign flush_byte = shift_q << (4'd8 - {1'b0, bit_idx_q});

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state_q <= RESYNC;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            shift_q     <= '0;
            bit_idx_q   <= '0;
            addr_cnt_q  <= '0;
            byte_full_q <= 1'b0;
            overflow_q  <= 1'b0;
            byte_valid  <= 1'b0;
            byte_data   <= '0;
            byte_addr   <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            pixel_count <= '0;
        end else begin
            byte_valid  <= 1'b0;
            frame_start <= frame_begin;
            frame_done  <= frame_end;

            if (frame_begin) begin
                bit_idx_q   <= '0;
                addr_cnt_q  <= '0;
                byte_full_q <= 1'b0;
                overflow_q  <= 1'b0;
                pixel_count <= '0;
            end

            // A completed byte leaves one cycle after its eighth bit; bits are >= 3 cycles apart.
            if (byte_full_q || state_q == FLUSH) begin
                byte_valid  <= 1'b1;
                byte_data   <= byte_full_q ? shift_q : flush_byte;
                byte_addr   <= addr_cnt_q;
                addr_cnt_q  <= addr_cnt_q + 1'b1;
                byte_full_q <= 1'b0;
            end

            if (take_bit) begin
                shift_q     <= {shift_q[6:0], data_s};
                bit_idx_q   <= bit_idx_d;
                pixel_count <= pixel_count + 17'd1;
                if (bit_idx_q == 3'd7) byte_full_q <= 1'b1;
            end

            if (drop_bit) overflow_q <= 1'b1;

            if (frame_end) frame_ok <= (pixel_count == PIX_MAX) && !overflow_q;
        end
    end

endmodule

// File: tb/tb_bitmask_stream_receiver.sv
// Randomised self-checking bench: drives the link protocol and compares bytes and frame
// results against a bit-list reference model of the receiver.
module tb_bitmask_stream_receiver;

    localparam int FP = 60;
    localparam int AW = 14;
    localparam int SS = 2;
    localparam int H  = 6;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          link_pclk = 1'b0;
    logic          link_in_frame = 1'b0;
    logic          link_wr_en = 1'b0;
    logic          link_data = 1'b0;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic [AW-1:0] byte_addr;
    logic          frame_start;
    logic          frame_done;
    logic          frame_ok;
    logic [16:0]   pixel_count;

    always #10 clk = ~clk;

    bitmask_stream_receiver #(
        .FRAME_PIXELS (FP),
        .ADDR_W       (AW),
        .SYNC_STAGES  (SS)
    ) dut (
        .clk           (clk),
        .nreset        (nreset),
        .link_pclk     (link_pclk),
        .link_in_frame (link_in_frame),
        .link_wr_en    (link_wr_en),
        .link_data     (link_data),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_addr     (byte_addr),
        .frame_start   (frame_start),
        .frame_done    (frame_done),
        .frame_ok      (frame_ok),
        .pixel_count   (pixel_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed traffic, collected on the falling clock edge.
    logic [31:0] got_data[$];
    logic [31:0] got_addr[$];
    logic [31:0] got_nb[$];
    logic [31:0] got_ok[$];
    logic [31:0] got_pc[$];
    int starts = 0;
    int order_err = 0;
    int stray = 0;
    bit in_prog = 1'b0;
    int nb = 0;

    always @(negedge clk) begin
        if (!nreset) begin
            in_prog = 1'b0;
            nb      = 0;
        end else begin
            if (frame_start === 1'b1) begin
                starts++;
                if (in_prog) order_err++;
                in_prog = 1'b1;
                nb      = 0;
            end
            if (byte_valid === 1'b1) begin
                got_data.push_back(32'(byte_data));
                got_addr.push_back(32'(byte_addr));
                if (!in_prog) stray++;
                nb++;
            end
            if (frame_done === 1'b1) begin
                if (!in_prog) order_err++;
                got_nb.push_back(32'(nb));
                got_ok.push_back(32'(frame_ok));
                got_pc.push_back(32'(pixel_count));
                in_prog = 1'b0;
            end
        end
    end

    // Reference model state.
    logic [31:0] exp_data[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_nb[$];
    logic [31:0] exp_ok[$];
    logic [31:0] exp_pc[$];
    int exp_starts = 0;
    bit acc_q[$];
    bit tx_bits[$];
    bit tx_we[$];

    // Accepted bits up to FP are kept, packed MSB-first, the last byte zero-padded.
    task automatic build_expect();
        int n, kept, nbytes;
        logic [7:0] b;
        n      = acc_q.size();
        kept   = (n < FP) ? n : FP;
        nbytes = (kept + 7) / 8;
        for (int i = 0; i < nbytes; i++) begin
            b = 8'h00;
            for (int j = 0; j < 8; j++) begin
                if (8*i + j < kept) b[7-j] = acc_q[8*i + j];
            end
            exp_data.push_back(32'(b));
            exp_addr.push_back(32'(i));
        end
        exp_nb.push_back(32'(nbytes));
        exp_ok.push_back(32'(n == FP));
        exp_pc.push_back(32'(kept));
        exp_starts++;
        acc_q.delete();
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One pclk period; lat = low-phase cycle in which byte_valid was first seen (-1 if never).
    task automatic send_bit(input bit b, input bit we, input bit drop_frame, output int lat);
        lat        = -1;
        link_data  = b;
        link_wr_en = we;
        link_pclk  = 1'b1;
        cyc(H);
        link_pclk = 1'b0;
        if (drop_frame) link_in_frame = 1'b0;
        for (int k = 1; k <= H; k++) begin
            cyc(1);
            if (byte_valid === 1'b1 && lat < 0) lat = k;
        end
    endtask

    task automatic send_frame(input bit coincide, input int gap, input bit meas);
        int lat;
        bit last;
        link_in_frame = 1'b1;
        cyc(4);
        for (int i = 0; i < tx_bits.size(); i++) begin
            last = (i == tx_bits.size() - 1);
            send_bit(tx_bits[i], tx_we[i], coincide && last, lat);
            if (tx_we[i]) begin
                acc_q.push_back(tx_bits[i]);
                if (meas && acc_q.size() == 8) check("latency", 32'(lat), 32'(SS + 2));
            end
        end
        if (!coincide || tx_bits.size() == 0) begin
            cyc(2);
            link_in_frame = 1'b0;
        end
        link_wr_en = 1'b0;
        cyc(gap);
        build_expect();
        tx_bits.delete();
        tx_we.delete();
    endtask

    function automatic logic [31:0] peek(input int i);
        return (i < got_data.size()) ? got_data[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, "_nframes"}, 32'(got_nb.size()), 32'(exp_nb.size()));
        while (got_nb.size() > 0 && exp_nb.size() > 0) begin
            check({tag, "_frame_bytes"}, got_nb.pop_front(), exp_nb.pop_front());
            check({tag, "_frame_ok"}, got_ok.pop_front(), exp_ok.pop_front());
            check({tag, "_pixel_count"}, got_pc.pop_front(), exp_pc.pop_front());
        end
        check({tag, "_nbytes"}, 32'(got_data.size()), 32'(exp_data.size()));
        while (got_data.size() > 0 && exp_data.size() > 0) begin
            check({tag, "_byte_data"}, got_data.pop_front(), exp_data.pop_front());
            check({tag, "_byte_addr"}, got_addr.pop_front(), exp_addr.pop_front());
        end
        check({tag, "_starts"}, 32'(starts), 32'(exp_starts));
        check({tag, "_order"}, 32'(order_err), 32'd0);
        check({tag, "_stray"}, 32'(stray), 32'd0);
        got_data.delete(); got_addr.delete(); got_nb.delete(); got_ok.delete(); got_pc.delete();
        exp_data.delete(); exp_addr.delete(); exp_nb.delete(); exp_ok.delete(); exp_pc.delete();
    endtask

    initial begin
        int lat;
        int sent;
        logic [15:0] pat;

        repeat (3) @(posedge clk);
        #1;
        check("rst_strobes", {28'd0, byte_valid, frame_start, frame_done, frame_ok}, 32'd0);
        check("rst_byte_data", 32'(byte_data), 32'd0);
        check("rst_byte_addr", 32'(byte_addr), 32'd0);
        check("rst_pixel_count", 32'(pixel_count), 32'd0);
        nreset = 1'b1;
        cyc(5);

        // Clean frame, alternating 1,0, exactly FP bits.
        for (int i = 0; i < FP; i++) begin
            tx_bits.push_back(i % 2 == 0);
            tx_we.push_back(1'b1);
        end
        send_frame(1'b0, 10, 1'b1);
        cyc(30);
        check("clean_first_byte", peek(0), 32'h0000_00AA);
        compare_all("clean");

        // Short frame: 13 ones.
        for (int i = 0; i < 13; i++) begin
            tx_bits.push_back(1'b1);
            tx_we.push_back(1'b1);
        end
        send_frame(1'b0, 10, 1'b0);
        cyc(30);
        check("short_byte0", peek(0), 32'h0000_00FF);
        check("short_byte1", peek(1), 32'h0000_00F8);
        compare_all("short");

        // Overlong frame: FP+5 random bits.
        for (int i = 0; i < FP + 5; i++) begin
            tx_bits.push_back(1'($urandom_range(0, 1)));
            tx_we.push_back(1'b1);
        end
        send_frame(1'b0, 10, 1'b0);
        cyc(30);
        compare_all("overlong");

        // wr_en gaps: every third pclk invalid, payload 0x3C then 0x5A.
        pat  = 16'h3C5A;
        sent = 0;
        for (int p = 0; sent < 16; p++) begin
            if (p % 3 == 2) begin
                tx_bits.push_back(1'($urandom_range(0, 1)));
                tx_we.push_back(1'b0);
            end else begin
                tx_bits.push_back(pat[15 - sent]);
                tx_we.push_back(1'b1);
                sent++;
            end
        end
        send_frame(1'b0, 10, 1'b0);
        cyc(30);
        check("gaps_byte0", peek(0), 32'h0000_003C);
        check("gaps_byte1", peek(1), 32'h0000_005A);
        compare_all("gaps");

        // wr_en and pclk activity outside a frame must be ignored.
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), 1'b1, 1'b0, lat);
        link_wr_en = 1'b0;
        cyc(30);
        compare_all("idle_wr");

        // Reset mid-frame, released while in_frame is still high.
        link_in_frame = 1'b1;
        cyc(4);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1, 1'b0, lat);
        exp_starts++;
        nreset = 1'b0;
        cyc(3);
        nreset = 1'b1;
        for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)), 1'b1, 1'b0, lat);
        link_in_frame = 1'b0;
        link_wr_en    = 1'b0;
        cyc(30);
        compare_all("midreset");

        // Back-to-back random frames with a 4-cycle gap.
        for (int f = 0; f < 20; f++) begin
            int len;
            len = $urandom_range(0, FP + 10);
            for (int i = 0; i < len; i++) begin
                tx_bits.push_back(1'($urandom_range(0, 1)));
                tx_we.push_back($urandom_range(0, 9) != 0);
            end
            send_frame(1'($urandom_range(0, 1)), 4, 1'b0);
        end
        cyc(40);
        compare_all("b2b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
